// File: rtl/simple_ctrl.sv
// Multi-cycle sequencer for a small accumulator-style datapath: fetches from an
// asynchronous ROM, decodes ALU/NOP/JMP/BZ/HALT and drives register-file/ALU enables.
module simple_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instr_in,
  input  logic        zero_flag,
  output logic [7:0]  pc,
  output logic [15:0] instruction_wire,
  output logic [1:0]  RF_addr,
  output logic        RF_we,
  output logic        A_ce,
  output logic        ALU_ce,
  output logic [2:0]  ALU_opcode_wire,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPA    = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [15:0] ir_reg, ir_next;

  logic [3:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm;

  assign op  = ir_reg[15:12];
  assign rd  = ir_reg[11:10];
  assign rs  = ir_reg[9:8];
  assign imm = ir_reg[7:0];

  assign pc               = pc_reg;
  assign instruction_wire = ir_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= 8'h00;
      ir_reg    <= 16'h0000;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    ir_next         = ir_reg;
    RF_addr         = 2'b00;
    RF_we           = 1'b0;
    A_ce            = 1'b0;
    ALU_ce          = 1'b0;
    ALU_opcode_wire = 3'b000;
    halted          = 1'b0;
    illegal         = 1'b0;

    case (state_reg)
      S_FETCH: begin
        if (run) begin
          ir_next    = instr_in;
          pc_next    = pc_reg + 8'd1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        state_next = S_FETCH;
        if (!op[3]) begin
          state_next = S_OPA;
        end else begin
          case (op)
            4'b1000: ;
            4'b1001: pc_next = imm;
            4'b1010: if (zero_flag) pc_next = imm;
            4'b1111: state_next = S_HALT;
            // Undefined control opcodes flag once and fall through as a NOP.
            default: illegal = 1'b1;
          endcase
        end
      end

      S_OPA: begin
        RF_addr    = rs;
        A_ce       = 1'b1;
        state_next = S_EXEC;
      end

      S_EXEC: begin
        RF_addr         = rd;
        ALU_ce          = 1'b1;
        ALU_opcode_wire = op[2:0];
        state_next      = S_WB;
      end

      S_WB: begin
        RF_addr    = rd;
        RF_we      = 1'b1;
        state_next = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_simple_ctrl.sv
// Cycle-accurate table of expected sequencer outputs; expectations are queued as
// stimulus is driven and checked one cycle later by an independent monitor.
module tb_simple_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] instr_in;
  logic        zero_flag;
  logic [7:0]  pc;
  logic [15:0] instruction_wire;
  logic [1:0]  RF_addr;
  logic        RF_we;
  logic        A_ce;
  logic        ALU_ce;
  logic [2:0]  ALU_opcode_wire;
  logic        halted;
  logic        illegal;

  logic [15:0] rom [256];

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] CN   = 5'b00000;
  localparam logic [4:0] CWE  = 5'b10000;
  localparam logic [4:0] CA   = 5'b01000;
  localparam logic [4:0] CALU = 5'b00100;
  localparam logic [4:0] CHLT = 5'b00010;
  localparam logic [4:0] CILL = 5'b00001;

  typedef struct {
    int          tag;
    logic        run;
    logic        zf;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [1:0]  addr;
    logic [4:0]  ctl;
    logic [2:0]  op;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  vec_t sb[$];

  simple_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .instr_in        (instr_in),
    .zero_flag       (zero_flag),
    .pc              (pc),
    .instruction_wire(instruction_wire),
    .RF_addr         (RF_addr),
    .RF_we           (RF_we),
    .A_ce            (A_ce),
    .ALU_ce          (ALU_ce),
    .ALU_opcode_wire (ALU_opcode_wire),
    .halted          (halted),
    .illegal         (illegal)
  );

  assign instr_in = rom[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input int tag, input logic r, input logic z, input logic [7:0] p,
                              input logic [15:0] i, input logic [1:0] a, input logic [4:0] c,
                              input logic [2:0] o);
    vec_t v;
    v.tag = tag; v.run = r; v.zf = z; v.pc = p; v.ir = i; v.addr = a; v.ctl = c; v.op = o;
    return v;
  endfunction

  // Monitor: each expectation describes DUT outputs just after the edge it was queued for.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk("pc", e.tag, 32'(pc), 32'(e.pc));
      chk("ir", e.tag, 32'(instruction_wire), 32'(e.ir));
      chk("rf_addr", e.tag, 32'(RF_addr), 32'(e.addr));
      chk("rf_we", e.tag, 32'(RF_we), 32'(e.ctl[4]));
      chk("a_ce", e.tag, 32'(A_ce), 32'(e.ctl[3]));
      chk("alu_ce", e.tag, 32'(ALU_ce), 32'(e.ctl[2]));
      chk("alu_op", e.tag, 32'(ALU_opcode_wire), 32'(e.op));
      chk("halted", e.tag, 32'(halted), 32'(e.ctl[1]));
      chk("illegal", e.tag, 32'(illegal), 32'(e.ctl[0]));
      chk("onehot", e.tag, 32'(int'(RF_we) + int'(A_ce) + int'(ALU_ce) <= 1), 32'd1);
      $display("vec %0d: pc=%02h ir=%04h addr=%0d we=%0b a=%0b alu=%0b op=%0d halt=%0b ill=%0b",
               e.tag, pc, instruction_wire, RF_addr, RF_we, A_ce, ALU_ce, ALU_opcode_wire,
               halted, illegal);
    end
  end

  // Drives one vector per cycle starting at a falling edge; ends on a falling edge.
  task automatic run_vec(input vec_t v);
    run       = v.run;
    zero_flag = v.zf;
    sb.push_back(v);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".pc"}, -1, 32'(pc), 32'h0);
    chk({name, ".ir"}, -1, 32'(instruction_wire), 32'h0);
    chk({name, ".ctl"}, -1, {27'd0, RF_we, A_ce, ALU_ce, halted, illegal}, 32'h0);
    chk({name, ".addr_op"}, -1, {27'd0, RF_addr, ALU_opcode_wire}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h5600;  // ALU op5 rd1 rs2
    rom[8'h01] = 16'h9040;  // JMP 0x40
    rom[8'h40] = 16'hA010;  // BZ 0x10, not taken
    rom[8'h41] = 16'hA010;  // BZ 0x10, taken
    rom[8'h10] = 16'hC000;  // undefined opcode
    rom[8'h11] = 16'h90FF;  // JMP 0xFF
    rom[8'hFF] = 16'h8000;  // NOP, pc wraps

    //                tag  run zf  pc     ir        addr ctl   op
    tbl_a.push_back(mk( 0, 1, 0, 8'h01, 16'h5600, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk( 1, 1, 0, 8'h01, 16'h5600, 2'd2, CA,   3'd0));
    tbl_a.push_back(mk( 2, 1, 0, 8'h01, 16'h5600, 2'd1, CALU, 3'd5));
    tbl_a.push_back(mk( 3, 1, 0, 8'h01, 16'h5600, 2'd1, CWE,  3'd0));
    tbl_a.push_back(mk( 4, 1, 0, 8'h01, 16'h5600, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk( 5, 1, 0, 8'h02, 16'h9040, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk( 6, 1, 1, 8'h40, 16'h9040, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk( 7, 1, 0, 8'h41, 16'hA010, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk( 8, 1, 0, 8'h41, 16'hA010, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk( 9, 1, 0, 8'h42, 16'hA010, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk(10, 1, 1, 8'h10, 16'hA010, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk(11, 1, 0, 8'h11, 16'hC000, 2'd0, CILL, 3'd0));
    tbl_a.push_back(mk(12, 1, 0, 8'h11, 16'hC000, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk(13, 1, 0, 8'h12, 16'h90FF, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk(14, 1, 0, 8'hFF, 16'h90FF, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk(15, 1, 0, 8'h00, 16'h8000, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk(16, 1, 0, 8'h00, 16'h8000, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk(17, 1, 0, 8'h01, 16'h5600, 2'd0, CN,   3'd0));
    tbl_a.push_back(mk(18, 1, 0, 8'h01, 16'h5600, 2'd2, CA,   3'd0));
    tbl_a.push_back(mk(19, 1, 0, 8'h01, 16'h5600, 2'd1, CALU, 3'd5));

    // After the mid-instruction reset: NOPs, a 10-cycle stall, then HALT at pc=3.
    tbl_b.push_back(mk(100, 1, 0, 8'h01, 16'h8000, 2'd0, CN, 3'd0));
    tbl_b.push_back(mk(101, 1, 0, 8'h01, 16'h8000, 2'd0, CN, 3'd0));
    for (int i = 0; i < 10; i++)
      tbl_b.push_back(mk(102 + i, 0, 0, 8'h01, 16'h8000, 2'd0, CN, 3'd0));
    tbl_b.push_back(mk(112, 1, 0, 8'h02, 16'h8000, 2'd0, CN,   3'd0));
    tbl_b.push_back(mk(113, 1, 0, 8'h02, 16'h8000, 2'd0, CN,   3'd0));
    tbl_b.push_back(mk(114, 1, 0, 8'h03, 16'h8000, 2'd0, CN,   3'd0));
    tbl_b.push_back(mk(115, 1, 0, 8'h03, 16'h8000, 2'd0, CN,   3'd0));
    tbl_b.push_back(mk(116, 1, 0, 8'h04, 16'hF000, 2'd0, CN,   3'd0));
    tbl_b.push_back(mk(117, 1, 0, 8'h04, 16'hF000, 2'd0, CHLT, 3'd0));
    tbl_b.push_back(mk(118, 0, 0, 8'h04, 16'hF000, 2'd0, CHLT, 3'd0));
    tbl_b.push_back(mk(119, 1, 1, 8'h04, 16'hF000, 2'd0, CHLT, 3'd0));
    tbl_b.push_back(mk(120, 0, 0, 8'h04, 16'hF000, 2'd0, CHLT, 3'd0));
    tbl_b.push_back(mk(121, 1, 0, 8'h04, 16'hF000, 2'd0, CHLT, 3'd0));

    rst = 1'b1;
    run = 1'b0;
    zero_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (tbl_a[i]) run_vec(tbl_a[i]);
    chk("sb_drain_a", -1, 32'(sb.size()), 32'd0);

    // DUT now sits in EXEC; an asynchronous reset must clear everything at once.
    rst = 1'b1;
    #1;
    chk_all_zero("rst_exec");
    @(posedge clk);
    #1;
    chk("rst_no_we", -1, 32'(RF_we), 32'd0);
    chk("rst_pc_held", -1, 32'(pc), 32'd0);
    @(negedge clk);
    rom[8'h00] = 16'h8000;
    rom[8'h01] = 16'h8000;
    rom[8'h02] = 16'h8000;
    rom[8'h03] = 16'hF000;
    rom[8'h04] = 16'h5600;
    rst = 1'b0;

    foreach (tbl_b[i]) run_vec(tbl_b[i]);
    chk("sb_drain_b", -1, 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
